// File: rtl/merge_ni_if.sv
`default_nettype none
// =============================================================================
// merge_ni_if : per-input write ports and merged output stream of merge_ni
// Revision    : 1.0
// =============================================================================
interface merge_ni_if #(
    parameter int N_IN       = 2,
    parameter int DATA_WIDTH = 32
);
    logic [N_IN-1:0]            valid_in;
    logic [N_IN*DATA_WIDTH-1:0] pxl_in;
    logic [N_IN-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]      pxl_out;
    logic                       valid_out;
    logic                       out_ready;
    logic                       out_last;
    logic [1:0]                 src_idx;
    logic                       frame_done;

    modport master (
        output valid_in, pxl_in, out_ready,
        input  in_ready, pxl_out, valid_out, out_last, src_idx, frame_done
    );

    modport slave (
        input  valid_in, pxl_in, out_ready,
        output in_ready, pxl_out, valid_out, out_last, src_idx, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/merge_ni.sv
`default_nettype none
// =============================================================================
// merge_ni : buffers N_IN feature maps and streams them out concatenated in input order
// Revision : 1.0
// =============================================================================
module merge_ni #(
    parameter int          N_IN       = 2,
    parameter int          D          = 220,
    parameter logic [31:0] C_LIST     = {8'd1, 8'd1, 8'd1, 8'd1},
    parameter int          DATA_WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  reset,
    merge_ni_if.slave  bus
);
    function automatic int t_words(input int k);
        return D * D * int'(C_LIST[8*k +: 8]);
    endfunction

    function automatic int max_words();
        int m;
        m = 0;
        for (int k = 0; k < N_IN; k++) begin
            if (t_words(k) > m) m = t_words(k);
        end
        return m;
    endfunction

    localparam int         MAX_T    = max_words();
    localparam int         CW       = $clog2(MAX_T + 1);
    localparam logic [1:0] LAST_SEL = 2'(N_IN - 1);

    logic [CW-1:0]         r_wr_cnt  [N_IN];
    logic [DATA_WIDTH-1:0] w_rd_data [N_IN];
    logic [N_IN-1:0]       w_in_ready;
    logic [N_IN-1:0]       w_wr_en;

    logic [1:0]            r_sel;
    logic [CW-1:0]         r_rd_cnt;
    logic [CW-1:0]         w_t_sel;
    logic [CW-1:0]         w_wr_sel;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_avail;
    logic                  w_issue;
    logic                  w_wrap;
    logic                  w_sel_end;

    logic [DATA_WIDTH-1:0] r_pxl_out;
    logic                  r_valid_out;
    logic                  r_out_last;
    logic [1:0]            r_src_idx;
    logic                  r_frame_done;

    always_comb begin
        w_in_ready = '0;
        w_wr_en    = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_in_ready[k] = r_wr_cnt[k] < CW'(t_words(k));
            w_wr_en[k]    = bus.valid_in[k] && w_in_ready[k];
        end
    end

    // Each input owns a RAM sized to its own map; contents are never cleared.
    for (genvar k = 0; k < N_IN; k++) begin : g_mem
        localparam int T_K = t_words(k);
        localparam int AW  = (T_K > 1) ? $clog2(T_K) : 1;

        logic [DATA_WIDTH-1:0] mem [T_K];

        always_ff @(posedge clk) begin
            if (w_wr_en[k]) begin
                mem[r_wr_cnt[k][AW-1:0]] <= bus.pxl_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        assign w_rd_data[k] = mem[r_rd_cnt[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_IN; k++) r_wr_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                if (w_wrap) begin
                    r_wr_cnt[k] <= '0;
                end else if (w_wr_en[k]) begin
                    r_wr_cnt[k] <= r_wr_cnt[k] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_t_sel   = '0;
        w_wr_sel  = '0;
        w_rd_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (r_sel == 2'(k)) begin
                w_t_sel   = CW'(t_words(k));
                w_wr_sel  = r_wr_cnt[k];
                w_rd_word = w_rd_data[k];
            end
        end
    end

    // Only committed write counts are compared, so a word becomes readable the cycle after it lands.
    assign w_avail   = r_rd_cnt < w_wr_sel;
    assign w_issue   = w_avail && (!r_valid_out || bus.out_ready);
    assign w_wrap    = r_valid_out && bus.out_ready && r_out_last;
    assign w_sel_end = (r_rd_cnt + CW'(1)) == w_t_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel        <= '0;
            r_rd_cnt     <= '0;
            r_pxl_out    <= '0;
            r_valid_out  <= 1'b0;
            r_out_last   <= 1'b0;
            r_src_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;

            // The last input parks at rd_cnt == T until the final handshake wraps the frame.
            if (w_wrap) begin
                r_sel    <= '0;
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                if (w_sel_end && (r_sel != LAST_SEL)) begin
                    r_sel    <= r_sel + 2'd1;
                    r_rd_cnt <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + CW'(1);
                end
            end

            if (w_issue) begin
                r_pxl_out   <= w_rd_word;
                r_src_idx   <= r_sel;
                r_valid_out <= 1'b1;
                r_out_last  <= (r_sel == LAST_SEL) && w_sel_end;
            end else if (r_valid_out && bus.out_ready) begin
                r_valid_out <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.pxl_out    = r_pxl_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.out_last   = r_out_last;
    assign bus.src_idx    = r_src_idx;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
